// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter: per-requester valid/ready,
// packed byte lanes and per-requester parity configuration.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            cfg_par_en;
    logic [NUM_REQ-1:0]            cfg_par_type;

    modport master (
        output req_valid, req_data, cfg_par_en, cfg_par_type,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_data, cfg_par_en, cfg_par_type,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX among NUM_REQ byte requesters,
// sequencing Data_valid/Busy one frame at a time with a start timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W        = $clog2(START_TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    uart_tx_arbiter_if.slave      req,
    output logic                  Data_valid,
    output logic [DATA_WIDTH-1:0] P_data,
    output logic                  Par_en,
    output logic                  Par_type,
    input  logic                  Busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  active,
    output logic                  frame_done,
    output logic                  err_timeout
);

    typedef enum logic [2:0] {ARB, LOAD, WAIT_BUSY, SENDING, DONE} state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      start_cnt;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  grant;
    logic [DATA_WIDTH-1:0] win_data;
    logic [ID_W-1:0]       next_id;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = ID_W'(idx);
            if (!found && req.req_valid[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) win_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Gated by rst so no accept strobe leaks out while the block is held in reset.
    assign grant         = rst && enable && !Busy && (state == ARB) && found;
    assign req.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    assign active        = (state != ARB);
    assign next_id       = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB;
            rr_ptr      <= '0;
            grant_id    <= '0;
            start_cnt   <= '0;
            Data_valid  <= 1'b0;
            P_data      <= '0;
            Par_en      <= 1'b0;
            Par_type    <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            Data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ARB: begin
                    if (grant) begin
                        P_data     <= win_data;
                        Par_en     <= req.cfg_par_en[winner];
                        Par_type   <= req.cfg_par_type[winner];
                        grant_id   <= winner;
                        Data_valid <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    start_cnt <= '0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Busy) begin
                        state <= SENDING;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                        // Counter is about to reach START_TIMEOUT-1: give up on this byte.
                        if (start_cnt == CNT_W'(START_TIMEOUT - 2)) begin
                            err_timeout <= 1'b1;
                            rr_ptr      <= next_id;
                            state       <= ARB;
                        end
                    end
                end
                SENDING: begin
                    if (!Busy) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= next_id;
                    state  <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a behavioural UART_TX stub
// and a frame-timeline reference model of the scheduler.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_WIDTH    = 8;
    localparam int START_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       busy;
    logic       data_valid;
    logic [7:0] p_data;
    logic       par_en;
    logic       par_type;
    logic [1:0] grant_id;
    logic       active;
    logic       frame_done;
    logic       err_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) req_if ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req_if.slave),
        .Data_valid(data_valid), .P_data(p_data), .Par_en(par_en), .Par_type(par_type),
        .Busy(busy), .grant_id(grant_id), .active(active),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // UART_TX stub: one cycle per bit, frame = start + data + optional parity + stop.
    int busy_cnt;
    bit uart_accept = 1'b1;
    bit stale_busy  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst)                           busy_cnt <= 0;
        else if (busy_cnt > 0)              busy_cnt <= busy_cnt - 1;
        else if (data_valid && uart_accept) busy_cnt <= 2 + DATA_WIDTH + int'(par_en);
    end

    assign busy = (busy_cnt != 0) || stale_busy;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;

    bit         has   [NUM_REQ];
    logic [7:0] bytev [NUM_REQ];
    int         ptr       = 0;
    bit         in_flight = 1'b0;
    int         t         = 0;
    bit         accept_m  = 1'b1;
    int         len       = 0;
    logic [7:0] exp_pdata   = '0;
    logic       exp_paren   = 1'b0;
    logic       exp_partype = 1'b0;
    int         exp_gid     = 0;
    bit         refill_all  = 1'b0;
    bit         rand_mode   = 1'b0;
    int         en_off      = 0;
    int         grant_log[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int end_t();
        return accept_m ? len + 3 : START_TIMEOUT;
    endfunction

    function automatic bit model_idle();
        return !in_flight || (t > end_t());
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!has[i] && (refill_all || (rand_mode && $urandom_range(0, 3) == 0))) begin
                has[i]   = 1'b1;
                bytev[i] = 8'($urandom);
            end
        end
        if (rand_mode) begin
            if ($urandom_range(0, 7) == 0) req_if.cfg_par_en   = 4'($urandom);
            if ($urandom_range(0, 7) == 0) req_if.cfg_par_type = 4'($urandom);
            if (in_flight && t == 2 && en_off == 0 && $urandom_range(0, 9) == 0) en_off = 25;
            stale_busy = model_idle() && ($urandom_range(0, 9) == 0);
        end
        if (en_off > 0) begin
            enable = 1'b0;
            en_off--;
        end else if (rand_mode) begin
            enable = ($urandom_range(0, 15) != 0);
        end else begin
            enable = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_if.req_valid[i]           = has[i];
            req_if.req_data[i*8 +: 8]     = bytev[i];
        end
    endtask

    // One clock of model vs DUT: drive on the falling edge, compare 1 ns later.
    task automatic runCycle();
        logic [3:0] exp_ready;
        int         w;
        int         idx;
        @(negedge clk);
        if (in_flight) t++;
        applyStimulus();
        #1;
        exp_ready = '0;
        w = -1;
        if (model_idle() && enable && !busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (ptr + k) % NUM_REQ;
                if (w < 0 && has[idx]) w = idx;
            end
        end
        if (w >= 0) exp_ready = 4'b0001 << w;
        if (frame_done) fd_count++;
        checkOutput("req_ready",   32'(req_if.req_ready), 32'(exp_ready));
        checkOutput("data_valid",  32'(data_valid),  32'(in_flight && t == 1));
        checkOutput("active",      32'(active),      32'(in_flight && t >= 1 && t <= end_t()));
        checkOutput("frame_done",  32'(frame_done),  32'(in_flight && accept_m && t == len + 3));
        checkOutput("err_timeout", 32'(err_timeout), 32'(in_flight && !accept_m && t == START_TIMEOUT + 1));
        checkOutput("p_data",      32'(p_data),      32'(exp_pdata));
        checkOutput("par_en",      32'(par_en),      32'(exp_paren));
        checkOutput("par_type",    32'(par_type),    32'(exp_partype));
        checkOutput("grant_id",    32'(grant_id),    32'(exp_gid));
        if (w >= 0) begin
            grant_log.push_back(w);
            has[w]      = 1'b0;
            exp_pdata   = bytev[w];
            exp_paren   = req_if.cfg_par_en[w];
            exp_partype = req_if.cfg_par_type[w];
            exp_gid     = w;
            ptr         = (w + 1) % NUM_REQ;
            in_flight   = 1'b1;
            t           = 0;
            accept_m    = rand_mode ? ($urandom_range(0, 5) != 0) : 1'b1;
            uart_accept = accept_m;
            len         = 2 + DATA_WIDTH + int'(exp_paren);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_dv"},     32'(data_valid),        32'(0));
        checkOutput({tag, "_ready"},  32'(req_if.req_ready),  32'(0));
        checkOutput({tag, "_pdata"},  32'(p_data),            32'(0));
        checkOutput({tag, "_active"}, 32'(active),            32'(0));
        checkOutput({tag, "_paren"},  32'(par_en),            32'(0));
        checkOutput({tag, "_gid"},    32'(grant_id),          32'(0));
    endtask

    task automatic resetModel();
        in_flight   = 1'b0;
        t           = 0;
        ptr         = 0;
        exp_pdata   = '0;
        exp_paren   = 1'b0;
        exp_partype = 1'b0;
        exp_gid     = 0;
        stale_busy  = 1'b0;
    endtask

    task automatic midFrameReset(input int at_t);
        int guard = 0;
        while (!(in_flight && t == at_t - 1) && guard < 200) begin
            runCycle();
            guard++;
        end
        checkOutput("rst_wait", 32'(guard < 200), 32'(1));
        @(negedge clk);
        #3;
        checkOutput("pre_rst_dv", 32'(data_valid), 32'(at_t == 1));
        rst = 1'b0;
        #1;
        checkReset("async_rst");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold_ready", 32'(req_if.req_ready), 32'(0));
        resetModel();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int fd_before;
        int expected_order[5] = '{0, 1, 2, 3, 0};

        // Reset with every requester valid: nothing may be accepted or launched.
        for (int i = 0; i < NUM_REQ; i++) has[i] = 1'b1;
        bytev[0] = 8'h3C;
        bytev[1] = 8'h55;
        bytev[2] = 8'h9A;
        bytev[3] = 8'hFF;
        req_if.cfg_par_en   = 4'b1101;
        req_if.cfg_par_type = 4'b1001;
        enable = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_if.req_valid[i]       = 1'b1;
            req_if.req_data[i*8 +: 8] = bytev[i];
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkReset("reset");
        end
        @(posedge clk);
        #2 rst = 1'b1;

        $display("[TB] round-robin with all requesters valid");
        refill_all = 1'b1;
        grant_log.delete();
        repeat (80) runCycle();
        for (int i = 0; i < 5; i++)
            checkOutput("rr_order", 32'((i < grant_log.size()) ? grant_log[i] : 99), 32'(expected_order[i]));
        refill_all = 1'b0;

        $display("[TB] randomized traffic with timeouts, stale Busy and enable drops");
        rand_mode = 1'b1;
        repeat (3000) runCycle();
        rand_mode  = 1'b0;
        stale_busy = 1'b0;

        $display("[TB] reset during LOAD and during SENDING");
        for (int i = 0; i < NUM_REQ; i++) has[i] = 1'b1;
        midFrameReset(1);
        repeat (3) runCycle();
        checkOutput("post_rst_grant", 32'(grant_log[grant_log.size()-1]), 32'(0));
        midFrameReset(6);
        repeat (20) runCycle();

        $display("[TB] enable dropped mid-frame");
        for (int i = 0; i < NUM_REQ; i++) has[i] = 1'b1;
        begin
            int guard = 0;
            while (!(in_flight && t == 2) && guard < 200) begin
                runCycle();
                guard++;
            end
            checkOutput("en_wait", 32'(guard < 200), 32'(1));
        end
        en_off    = 30;
        fd_before = fd_count;
        repeat (40) runCycle();
        checkOutput("en_drop_frame_done", 32'(fd_count - fd_before), 32'(1));
        repeat (30) runCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART_TX transmitter among NUM_REQ byte requesters. It accepts a byte per requester over a valid/ready handshake and applies that requester's parity configuration. It sequences the transmitter's Data_valid/Busy protocol one frame at a time and reports completion and start-timeout errors. It sits between the host-side producers and the UART_TX top, and drives UART_TX's Data_valid, P_data, Par_en and Par_type directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame payload width; must match UART_TX P_data
START_TIMEOUT, 4, cycles to wait for Busy to rise after a Data_valid pulse before declaring an error (>=2)

Ports:
clk  in  1  system clock, shared with UART_TX
rst  in  1  asynchronous active-low reset
enable  in  1  when 0, no new grants; an in-flight frame still completes
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept strobe; combinational in ARB
cfg_par_en  in  NUM_REQ  per-requester parity enable
cfg_par_type  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
Data_valid  out  1  to UART_TX; registered one-cycle pulse
P_data  out  DATA_WIDTH  to UART_TX; registered, held for the whole frame
Par_en  out  1  to UART_TX; registered, held for the whole frame
Par_type  out  1  to UART_TX; registered, held for the whole frame
Busy  in  1  from UART_TX
grant_id  out  clog2(NUM_REQ)  requester owning the current/last frame
active  out  1  high in every state except ARB
frame_done  out  1  one-cycle pulse when a frame finishes
err_timeout  out  1  one-cycle pulse when Busy fails to rise

Behaviour:
- Reset (rst=0, async): state=ARB, rr_ptr=0, grant_id=0, Data_valid=0, P_data=0, Par_en=0, Par_type=0, frame_done=0, err_timeout=0, timeout counter=0. req_ready=0 while rst=0. Reset mid-frame drops the frame silently; Data_valid falls immediately.
- States: ARB, LOAD, WAIT_BUSY, SENDING, DONE.
- ARB:
  - Grant condition: enable=1, Busy=0 and |req_valid.
  - Winner: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 in the same cycle; a transfer occurs on valid&ready at the clock edge.
  - On that edge: capture req_data[winner], cfg_par_en[winner] and cfg_par_type[winner] into P_data/Par_en/Par_type; grant_id=winner; go to LOAD.
  - Otherwise stay in ARB; req_ready=0.
- LOAD: Data_valid=1 for exactly this cycle; clear timeout counter; next state WAIT_BUSY.
- WAIT_BUSY:
  - Busy=1 -> SENDING.
  - Else increment the counter. When the counter reaches START_TIMEOUT-1 with Busy still 0: pulse err_timeout for one cycle, set rr_ptr=grant_id+1 mod NUM_REQ, go to ARB. The byte is dropped.
- SENDING: stay while Busy=1; Busy=0 -> DONE.
- DONE: frame_done=1 for one cycle; rr_ptr=grant_id+1 mod NUM_REQ; go to ARB.
- Frame-stable rule: P_data, Par_en and Par_type change only on the ARB grant edge or on reset.
- Latency: grant edge -> Data_valid high the next cycle -> Busy expected 1 cycle later. Minimum gap between two Data_valid pulses is frame length + 3 cycles (DONE, ARB, LOAD).
- Only one frame in flight. req_valid and cfg changes outside ARB have no effect until the next ARB cycle.
- enable deasserted during LOAD/WAIT_BUSY/SENDING: the frame completes normally, then the block stays in ARB.
- Busy=1 while in ARB (external/stale): no grant until Busy=0.
- rr_ptr wraps NUM_REQ-1 -> 0.

Test Plan:
- Reset: hold rst=0 3 cycles with all req_valid=1 -> Data_valid=0, req_ready=0, P_data=0, active=0; after release, first grant to requester 0.
- Single frame: req_valid=4'b0100, req_data[23:16]=8'h9A, cfg_par_en[2]=1, cfg_par_type[2]=0.
  - req_ready=4'b0100 for one cycle; Data_valid one pulse; P_data=8'h9A, Par_en=1, Par_type=0 stable until frame_done.
  - TX_out frame: start, 0,1,0,1,1,0,0,1, parity 0, stop; grant_id=2.
- Round-robin fairness: all four requesters continuously valid -> grant order 0,1,2,3,0 with one frame_done per grant and no back-to-back grants to the same requester.
- Mixed parity: requester1 Par_en=0, requester3 Par_en=1, Par_type=1, data 8'hFF -> requester1 frame has no parity bit; requester3 parity bit=1; Par_en/Par_type switch only at the grant edge.
- Timeout: Busy forced 0 after Data_valid -> err_timeout pulses START_TIMEOUT cycles after LOAD; no frame_done; rr_ptr advances; next request is granted normally.
- Reset mid-SENDING and enable drop: rst=0 during a frame -> outputs return to reset values asynchronously. enable=0 during a frame -> that frame's frame_done still pulses, then no further req_ready until enable=1.
